// File: rtl/add_accumulator_if.sv
// add_accumulator_if: the operand-in and result-out handshakes of add_accumulator.
// Ports: in_valid/in_ready/in_data/in_last carry operand beats from upstream;
//        out_valid/out_ready/out_sum/out_overflow/out_count carry the packet result downstream.
interface add_accumulator_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_overflow;
  logic [CW-1:0] out_count;

  // master: the environment around the accumulator (drives operands, consumes results)
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, out_count
  );

  // slave: the accumulator itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, out_count
  );
endinterface

// File: rtl/add_accumulator.sv
// add_accumulator: sums the beats of a packet, reporting sum mod 2^N, sticky carry and beat count.
// Ports: clk, rst (async active-high); bus (slave modport) carries operand beats and packet results.
// Latency: result valid 1 cycle after the last beat is accepted; no new beats while a result waits.

// ripplecarry_adder: N-bit ripple-carry adder built from full-adder cells.
// Ports: a, b operands; c_in carry in; sum N-bit result; c_out carry out of the top bit.
module ripplecarry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  logic [N:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[N];
endmodule

module add_accumulator #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  add_accumulator_if.slave  bus
);
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state;
  logic [N-1:0]  acc;
  logic          ovf;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [N-1:0]  add_sum;
  logic          add_cout;

  // The adder is the only arithmetic source: acc + operand, no carry in.
  ripplecarry_adder #(.N(N)) u_adder (
    .a     (acc),
    .b     (bus.in_data),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Handshake flags are registered alongside the state so in_ready/out_valid
  // never depend combinationally on in_valid or out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // in_ready_q is always 1 here, so in_valid alone means acceptance.
          if (bus.in_valid) begin
            acc <= add_sum;
            ovf <= ovf | add_cout;
            if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
            if (bus.in_last) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Result consumed: clear for the next packet. No beat is taken on
          // this edge because in_ready_q is low for all of DONE.
          if (bus.out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          acc         <= '0;
          ovf         <= 1'b0;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = acc;
  assign bus.out_overflow = ovf;
  assign bus.out_count    = cnt;
endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand and accumulator width in bits.
REQ-002 SHALL have parameter CW, default 8, meaning beat-counter width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-007 SHALL have port in_data  input  N  operand to add.
REQ-008 SHALL have port in_last  input  1  operand is the final beat of a packet.
REQ-009 SHALL have port out_valid  output  1  packet result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_sum  output  N  accumulated sum modulo 2^N.
REQ-012 SHALL have port out_overflow  output  1  sticky: some beat in the packet produced a carry-out.
REQ-013 SHALL have port out_count  output  CW  number of beats accepted in the packet.

Function
REQ-014 SHALL compute each addition with one ripplecarry_adder #(.N(N)) instance: a=acc, b=in_data, c_in=0; its sum and c_out are the only arithmetic source.
REQ-015 SHALL implement FSM states ACCUM and DONE; in_ready=1 only in ACCUM; out_valid=1 only in DONE.
REQ-016 SHALL accept a beat when in_valid && in_ready; on acceptance, acc <= adder sum, ovf <= ovf | adder c_out, cnt <= cnt+1 saturating at 2^CW-1.
REQ-017 SHALL ignore in_data/in_last when in_valid=0 or in DONE; no state changes.
REQ-018 SHALL transition ACCUM->DONE on the edge accepting a beat with in_last=1; out_valid asserts the following cycle (latency 1 cycle from final accept).
REQ-019 SHALL drive out_sum=acc, out_overflow=ovf, out_count=cnt directly from registers; values stable for all of DONE.
REQ-020 SHALL, in DONE, hold out_valid=1 and all outputs until out_ready=1; on that edge clear acc, ovf, cnt to 0 and return to ACCUM.
REQ-021 SHALL NOT accept a beat on the same edge that the result is consumed (in_ready=0 throughout DONE); first beat of next packet accepted no earlier than the cycle after.
REQ-022 SHALL treat a single beat with in_last=1 as a complete packet (count=1).
REQ-023 SHALL wrap acc modulo 2^N on carry; wrap sets ovf, never altering sum bits beyond modulo arithmetic.
REQ-024 SHALL, when cnt is saturated, keep cnt at 2^CW-1 while still accumulating acc/ovf.
REQ-025 SHALL have no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-026 SHALL, on rst=1 at any time (including mid-packet or in DONE), immediately set state=ACCUM, acc=0, ovf=0, cnt=0, out_valid=0, in_ready=1 once rst deasserts; partial packets are discarded.
REQ-027 SHALL have all outputs at defined reset values while rst=1: out_sum=0, out_overflow=0, out_count=0, out_valid=0.

Verification (N=8, CW=8)
REQ-028 SHALL verify: assert rst 2 cycles then release -> out_valid=0, in_ready=1, out_sum=0, out_count=0.
REQ-029 SHALL verify: beats 63, 1, 32(last) back-to-back, out_ready=1 -> one cycle later out_valid=1, out_sum=96, out_overflow=0, out_count=3.
REQ-030 SHALL verify: beats 255, 1(last) -> out_sum=0, out_overflow=1, out_count=2; next packet 5(last) -> out_sum=5, out_overflow=0, out_count=1.
REQ-031 SHALL verify: result pending with out_ready=0 for 3 cycles while in_valid=1, in_data=7 -> out_valid held, in_ready=0, outputs unchanged; 7 not accumulated into any packet.
REQ-032 SHALL verify: beats 10, 20 accepted then rst pulsed mid-packet -> after release packet 3(last) yields out_sum=3, out_count=1, out_overflow=0.
REQ-033 SHALL verify: 300 beats of 1 with last on beat 300 -> out_count=255 (saturated), out_sum=44, out_overflow=1.
